// File: rtl/sevenseg_scan_decoder.sv
// ----------------------------------------------------------------------------
// sevenseg_scan_decoder
//   Reader side of a multiplexed seven-segment display bus. Samples the
//   active-low anode/segment lines, waits until a pattern has been stable for
//   STABLE_CYCLES synchronized samples, then decodes the segment pattern back
//   into a 4-bit digit for the single active display position. Used for
//   display loop-back self-test and for snooping an external display.
//
// Parameters
//   NUM_DIGITS     number of anode lines / digit positions scanned
//   STABLE_CYCLES  identical synchronized samples needed before capture (>=2)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   segment      active-low segments, bit6=a .. bit0=g
//   anode        active-low digit enables, bit0 = rightmost digit
//   bcd_out      decoded digits, lane i = bits [4i+3:4i] (4'hF when invalid)
//   digit_valid  lane i holds a validly decoded digit
//   frame_done   1-cycle pulse: every digit captured since the last pulse
//   bad_code     1-cycle pulse: stable undecodable pattern captured
//   anode_err    1-cycle pulse: stable pattern with more than one anode low
//
// Configuration
//   HEX_DECODE_EN  when defined, patterns A,b,C,d,E,F decode to 10..15.
// ----------------------------------------------------------------------------
module sevenseg_scan_decoder #(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              segment,
   input  logic [NUM_DIGITS-1:0]   anode,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    frame_done,
   output logic                    bad_code,
   output logic                    anode_err
);

   localparam int unsigned SW = NUM_DIGITS + 7;
   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 2);

   // Two-flop synchronizers
   logic [6:0]            seg_meta_q, seg_s_q;
   logic [NUM_DIGITS-1:0] an_meta_q,  an_s_q;

   // Stability tracking
   logic [SW-1:0] sample;
   logic [SW-1:0] prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          capture;

   // Output / frame state
   logic [4*NUM_DIGITS-1:0] bcd_q,   bcd_d;
   logic [NUM_DIGITS-1:0]   valid_q, valid_d;
   logic [NUM_DIGITS-1:0]   seen_q,  seen_d;
   logic                    frame_q, frame_d;
   logic                    bad_q,   bad_d;
   logic                    aerr_q,  aerr_d;

   logic [4:0]  dec;
   int unsigned low_cnt;

   // Returns {valid, value}; invalid patterns yield value 4'hF.
   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'b0000001: r = 5'h10;
         7'b1001111: r = 5'h11;
         7'b0010010: r = 5'h12;
         7'b0000110: r = 5'h13;
         7'b1001100: r = 5'h14;
         7'b0100100: r = 5'h15;
         7'b0100000: r = 5'h16;
         7'b0001111: r = 5'h17;
         7'b0000000: r = 5'h18;
         7'b0000100: r = 5'h19;
`ifdef HEX_DECODE_EN
         7'b0001000: r = 5'h1A;
         7'b1100000: r = 5'h1B;
         7'b0110001: r = 5'h1C;
         7'b1000010: r = 5'h1D;
         7'b0110000: r = 5'h1E;
         7'b0111000: r = 5'h1F;
`endif
         default:    r = 5'h0F;
      endcase
      return r;
   endfunction

   assign sample = {an_s_q, seg_s_q};

   // Capture fires only on the cnt PRE -> PRE+1 step, so a long stable
   // period (counter saturated) produces exactly one capture.
   always_comb begin
      cnt_d   = '0;
      capture = 1'b0;
      if (sample == prev_q) begin
         cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
         capture = (cnt_q == CNT_PRE);
      end
   end

   always_comb begin
      bcd_d   = bcd_q;
      valid_d = valid_q;
      seen_d  = seen_q;
      frame_d = 1'b0;
      bad_d   = 1'b0;
      aerr_d  = 1'b0;
      dec     = decode_seg(seg_s_q);
      low_cnt = 0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (!an_s_q[i]) low_cnt++;
      end
      if (capture) begin
         if (low_cnt == 1) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
               if (!an_s_q[i]) begin
                  bcd_d[4*i +: 4] = dec[3:0];
                  valid_d[i]      = dec[4];
                  seen_d[i]       = 1'b1;
               end
            end
            bad_d = ~dec[4];
            if (&seen_d) begin
               frame_d = 1'b1;
               seen_d  = '0;
            end
         end else if (low_cnt > 1) begin
            aerr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_meta_q <= '1;
         seg_s_q    <= '1;
         an_meta_q  <= '1;
         an_s_q     <= '1;
         prev_q     <= '1;
         cnt_q      <= '0;
         bcd_q      <= '1;
         valid_q    <= '0;
         seen_q     <= '0;
         frame_q    <= 1'b0;
         bad_q      <= 1'b0;
         aerr_q     <= 1'b0;
      end else begin
         seg_meta_q <= segment;
         seg_s_q    <= seg_meta_q;
         an_meta_q  <= anode;
         an_s_q     <= an_meta_q;
         prev_q     <= sample;
         cnt_q      <= cnt_d;
         bcd_q      <= bcd_d;
         valid_q    <= valid_d;
         seen_q     <= seen_d;
         frame_q    <= frame_d;
         bad_q      <= bad_d;
         aerr_q     <= aerr_d;
      end
   end

   assign bcd_out     = bcd_q;
   assign digit_valid = valid_q;
   assign frame_done  = frame_q;
   assign bad_code    = bad_q;
   assign anode_err   = aerr_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// ----------------------------------------------------------------------------
// tb_sevenseg_scan_decoder
//   Drives held anode/segment patterns and compares every output each cycle
//   against a reference model. The model treats the pins as runs of identical
//   values: a run lasting STABLE edges takes effect two edges (synchronizer
//   depth) after it completes its stability window; decoding is a table search.
// ----------------------------------------------------------------------------
module tb_sevenseg_scan_decoder;

   localparam int ND     = 4;
   localparam int STABLE = 4;
`ifdef HEX_DECODE_EN
   localparam int NVAL = 16;
`else
   localparam int NVAL = 10;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [6:0]    segment = '1;
   logic [ND-1:0] anode = '1;
   logic [4*ND-1:0] bcd_out;
   logic [ND-1:0] digit_valid;
   logic          frame_done, bad_code, anode_err;

   sevenseg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(STABLE)) dut (
      .clk(clk), .rst_n(rst_n), .segment(segment), .anode(anode),
      .bcd_out(bcd_out), .digit_valid(digit_valid), .frame_done(frame_done),
      .bad_code(bad_code), .anode_err(anode_err)
   );

   always #5 clk = ~clk;

   // Segment patterns (active low, a..g) for values 0..15
   logic [6:0] tbl [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
      7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000,
      7'b0111000 };

   int n_checks = 0;
   int n_pass   = 0;
   int n_frame, n_bad, n_aerr;

   // Reference model state
   logic [4*ND-1:0] m_bcd;
   logic [ND-1:0]   m_valid, m_seen;
   logic            m_frame, m_bad, m_aerr;
   int              edge_n;
   bit              run_ok;
   logic [ND+6:0]   run_val;
   int              run_len;
   logic [ND+6:0]   pend_q[$];
   int              pend_due[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_bcd = '1; m_valid = '0; m_seen = '0;
      m_frame = 0; m_bad = 0; m_aerr = 0;
      run_ok = 0; run_len = 0; edge_n = 0;
      pend_q.delete(); pend_due.delete();
   endtask

   task automatic model_apply(input logic [ND+6:0] s);
      logic [ND-1:0] an;
      logic [6:0]    seg;
      int low, idx, val;
      bit found;
      an = s[ND+6:7]; seg = s[6:0];
      low = 0; idx = 0;
      for (int i = 0; i < ND; i++) if (!an[i]) begin low++; idx = i; end
      if (low == 1) begin
         found = 0; val = 15;
         for (int v = 0; v < NVAL; v++) if (tbl[v] == seg) begin found = 1; val = v; end
         m_bcd[4*idx +: 4] = 4'(val);
         m_valid[idx] = found;
         m_bad = !found;
         m_seen[idx] = 1'b1;
         if (m_seen == '1) begin m_frame = 1; m_seen = '0; end
      end else if (low > 1) begin
         m_aerr = 1;
      end
   endtask

   task automatic model_edge(input logic [ND-1:0] an, input logic [6:0] seg);
      edge_n++;
      m_frame = 0; m_bad = 0; m_aerr = 0;
      if (run_ok && {an, seg} == run_val) run_len++;
      else begin run_ok = 1; run_val = {an, seg}; run_len = 1; end
      if (run_len == STABLE) begin
         pend_q.push_back({an, seg});
         pend_due.push_back(edge_n + 2);
      end
      if (pend_due.size() > 0 && pend_due[0] == edge_n) begin
         model_apply(pend_q[0]);
         void'(pend_q.pop_front());
         void'(pend_due.pop_front());
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, "_bcd"},   32'(bcd_out),     32'(m_bcd));
      check({tag, "_valid"}, 32'(digit_valid), 32'(m_valid));
      check({tag, "_frame"}, 32'(frame_done),  32'(m_frame));
      check({tag, "_bad"},   32'(bad_code),    32'(m_bad));
      check({tag, "_aerr"},  32'(anode_err),   32'(m_aerr));
   endtask

   // Called at a falling edge: drive, let one rising edge pass, then compare.
   task automatic step(input logic [ND-1:0] an, input logic [6:0] seg);
      anode = an; segment = seg;
      @(posedge clk);
      if (rst_n) model_edge(an, seg);
      @(negedge clk);
      compare_all("cyc");
      if (frame_done) n_frame++;
      if (bad_code)   n_bad++;
      if (anode_err)  n_aerr++;
   endtask

   task automatic hold(input logic [ND-1:0] an, input logic [6:0] seg, input int len);
      for (int k = 0; k < len; k++) step(an, seg);
   endtask

   task automatic clr_counts();
      n_frame = 0; n_bad = 0; n_aerr = 0;
   endtask

   logic [15:0] exp_bcd;
   logic [3:0]  lane1_exp;

   initial begin
      // Asynchronous reset without any clock edge
      #1 rst_n = 1'b0;
      #1 model_reset();
      compare_all("rst_async");
      check("rst_bcd", 32'(bcd_out), 32'h0000FFFF);
      @(negedge clk);
      for (int k = 0; k < 4; k++) step(4'($urandom), 7'($urandom));
      rst_n = 1'b1;

      // Single digit: lane0 = 2 exactly at the 6th clock
      clr_counts();
      for (int k = 1; k <= 10; k++) begin
         step(4'b1110, 7'b0010010);
         if (k == 5) check("d1_lat_before", 32'(bcd_out[3:0]), 32'hF);
         if (k == 6) begin
            check("d1_lat_lane0", 32'(bcd_out[3:0]), 32'h2);
            check("d1_lat_valid", 32'(digit_valid), 32'h1);
         end
      end
      check("d1_pulses", 32'(n_frame + n_bad + n_aerr), 32'd0);

      // Full scan 1,2,3,4
      clr_counts();
      hold(4'b1110, tbl[1], 8);
      hold(4'b1101, tbl[2], 8);
      hold(4'b1011, tbl[3], 8);
      hold(4'b0111, tbl[4], 8);
      check("scan_bcd",   32'(bcd_out),     32'h4321);
      check("scan_valid", 32'(digit_valid), 32'hF);
      check("scan_frame_cnt", 32'(n_frame), 32'd1);

      // Glitch shorter than the stability window is ignored
      clr_counts();
      hold(4'b1110, tbl[5], 8);
      hold(4'b1101, 7'b0000110, 3);
      hold(4'b1011, tbl[6], 8);
      check("glitch_lane1", 32'(bcd_out[7:4]), 32'h2);
      check("glitch_pulses", 32'(n_frame + n_bad + n_aerr), 32'd0);

      // Undecodable pattern, then a hex letter
      clr_counts();
      hold(4'b1101, 7'b1111110, 8);
      check("bad_cnt",   32'(n_bad), 32'd1);
      check("bad_lane1", 32'(bcd_out[7:4]), 32'hF);
      check("bad_valid1", 32'(digit_valid[1]), 32'd0);
      clr_counts();
      hold(4'b1101, 7'b0001000, 8);
`ifdef HEX_DECODE_EN
      lane1_exp = 4'hA;
      check("hexA_valid1", 32'(digit_valid[1]), 32'd1);
      check("hexA_bad_cnt", 32'(n_bad), 32'd0);
`else
      lane1_exp = 4'hF;
      check("hexA_valid1", 32'(digit_valid[1]), 32'd0);
      check("hexA_bad_cnt", 32'(n_bad), 32'd1);
`endif
      check("hexA_lane1", 32'(bcd_out[7:4]), 32'(lane1_exp));

      // Two anodes low: error pulse, lanes unchanged
      clr_counts();
      hold(4'b1100, tbl[8], 8);
      exp_bcd = {4'h4, 4'h6, lane1_exp, 4'h5};
      check("aerr_cnt", 32'(n_aerr), 32'd1);
      check("aerr_bcd", 32'(bcd_out), 32'(exp_bcd));
      check("aerr_other", 32'(n_frame + n_bad), 32'd0);

      // Reset in the middle of a scan
      hold(4'b0111, tbl[7], 3);
      #2 rst_n = 1'b0;
      #1 model_reset();
      compare_all("rst_mid");
      check("rst_mid_bcd", 32'(bcd_out), 32'h0000FFFF);
      @(negedge clk);
      for (int k = 0; k < 3; k++) step(4'($urandom), 7'($urandom));
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step(4'b0111, tbl[9]);
         if (k == 5) check("post_rst_before", 32'(bcd_out[15:12]), 32'hF);
         if (k == 6) check("post_rst_lane3", 32'(bcd_out[15:12]), 32'h9);
      end

      // Randomized holds
      for (int h = 0; h < 150; h++) begin
         logic [ND-1:0] an;
         logic [6:0]    seg;
         int r;
         r = $urandom_range(0, 9);
         if (r <= 5)      an = ~(4'(1) << $urandom_range(0, ND-1));
         else if (r == 6) an = '1;
         else             an = 4'($urandom);
         if ($urandom_range(0, 9) < 7) seg = tbl[$urandom_range(0, 15)];
         else                          seg = 7'($urandom);
         hold(an, seg, $urandom_range(1, 9));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
